// File: rtl/switch_allocator_pkg.sv
// Shared router defines: output port indices and allocator FSM encoding.
// Consumed by switch_allocator and route_compute.
package switch_allocator_pkg;

  localparam int N_PORTS    = 6;
  localparam int PORT_N     = 0;
  localparam int PORT_E     = 1;
  localparam int PORT_S     = 2;
  localparam int PORT_W     = 3;
  localparam int PORT_L     = 4;
  localparam int PORT_SER_E = 5;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } port_st_t;

endpackage

// File: rtl/switch_allocator_rr_arbiter.sv
// Cyclic priority picker: the first set request searched from ptr+1 wins.
// Produces a one-hot grant, the winner index and an any-grant flag.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         any
);

  logic [W-1:0] w_j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    w_j = '0;
    for (int k = 1; k <= N; k++) begin
      w_j = W'((int'(ptr) + k) % N);
      if (!any && req[w_j]) begin
        any      = 1'b1;
        gnt[w_j] = 1'b1;
        idx      = w_j;
      end
    end
  end

endmodule

// File: rtl/switch_allocator.sv
// Output-port allocator: per-port round-robin lock until tail, retry drop.
// Optional per-port grant counters under ALLOC_STATS_EN.
module switch_allocator
  import switch_allocator_pkg::*;
#(
  parameter int N_IN      = 4,
  parameter int IN_W      = 2,
  parameter int RETRY_MAX = 8
`ifdef ALLOC_STATS_EN
  ,
  parameter int STAT_W    = 16
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
`ifdef ALLOC_STATS_EN
  input  logic                      clr_stats,
  output logic [N_PORTS*STAT_W-1:0] stat_grants,
`endif
  input  logic [N_IN-1:0]           in_valid,
  input  logic [N_IN*N_PORTS-1:0]   in_req,
  input  logic [N_IN-1:0]           in_tail,
  input  logic [N_IN-1:0]           in_retry,
  input  logic [N_PORTS-1:0]        link_up,
  input  logic [N_PORTS-1:0]        out_ready,
  output logic [N_IN*N_PORTS-1:0]   gnt,
  output logic [N_PORTS-1:0]        out_valid,
  output logic [N_PORTS*IN_W-1:0]   out_sel,
  output logic [N_IN-1:0]           drop_req,
  output logic [N_PORTS-1:0]        abort
);

  port_st_t         r_state [N_PORTS];
  logic [N_IN-1:0]  r_gnt_p [N_PORTS];
  logic [IN_W-1:0]  r_sel   [N_PORTS];
  logic [IN_W-1:0]  r_ptr   [N_PORTS];
  logic [N_PORTS-1:0] r_abort;
  logic [7:0]       r_rcnt  [N_IN];
  logic [N_IN-1:0]  r_drop;

  logic [N_IN-1:0]    w_locked_in;
  logic [N_PORTS-1:0] w_avail [N_IN];
  logic [N_PORTS-1:0] w_low   [N_IN];
  logic [N_IN-1:0]    w_req   [N_PORTS];
  logic [N_IN-1:0]    w_arb_gnt [N_PORTS];
  logic [IN_W-1:0]    w_arb_idx [N_PORTS];
  logic [N_PORTS-1:0] w_arb_any;
  logic [N_PORTS-1:0] w_ok;
  logic [N_IN-1:0]    w_taken;

  always_comb begin
    w_locked_in = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      if (r_state[p] == ST_LOCKED) w_locked_in |= r_gnt_p[p];
    end
  end

  // Each input asks for only its lowest live port.
  always_comb begin
    for (int i = 0; i < N_IN; i++) begin
      w_avail[i] = in_req[i*N_PORTS +: N_PORTS] & link_up;
      w_low[i]   = w_avail[i] & (-w_avail[i]);
    end
  end

  always_comb begin
    for (int p = 0; p < N_PORTS; p++) begin
      w_req[p] = '0;
      for (int i = 0; i < N_IN; i++) begin
        w_req[p][i] = in_valid[i] & ~w_locked_in[i] & w_low[i][p]
                    & out_ready[p] & (r_state[p] == ST_IDLE);
      end
    end
  end

  for (genvar gp = 0; gp < N_PORTS; gp++) begin : g_arb
    rr_arbiter #(.N(N_IN), .W(IN_W)) u_arb (
      .req (w_req[gp]),
      .ptr (r_ptr[gp]),
      .gnt (w_arb_gnt[gp]),
      .idx (w_arb_idx[gp]),
      .any (w_arb_any[gp])
    );
  end

  // Lower port index wins an input picked by two ports.
  always_comb begin
    w_taken = '0;
    w_ok    = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      w_ok[p] = w_arb_any[p] & ~|(w_arb_gnt[p] & w_taken);
      if (w_ok[p]) w_taken |= w_arb_gnt[p];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_abort <= '0;
      for (int p = 0; p < N_PORTS; p++) begin
        r_state[p] <= ST_IDLE;
        r_gnt_p[p] <= '0;
        r_sel[p]   <= '0;
        r_ptr[p]   <= IN_W'(N_IN - 1);
      end
    end else begin
      r_abort <= '0;
      for (int p = 0; p < N_PORTS; p++) begin
        unique case (r_state[p])
          ST_IDLE: begin
            if (w_ok[p]) begin
              r_state[p] <= ST_LOCKED;
              r_gnt_p[p] <= w_arb_gnt[p];
              r_sel[p]   <= w_arb_idx[p];
              r_ptr[p]   <= w_arb_idx[p];
            end
          end
          ST_LOCKED: begin
            if (!link_up[p]) begin
              r_state[p] <= ST_IDLE;
              r_gnt_p[p] <= '0;
              r_sel[p]   <= '0;
              r_abort[p] <= 1'b1;
            end else if (in_valid[r_sel[p]] && out_ready[p]
                         && in_tail[r_sel[p]]) begin
              r_state[p] <= ST_IDLE;
              r_gnt_p[p] <= '0;
              r_sel[p]   <= '0;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop <= '0;
      for (int i = 0; i < N_IN; i++) r_rcnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_IN; i++) begin
        if (in_valid[i] && in_retry[i]) begin
          if (r_rcnt[i] == 8'(RETRY_MAX - 1)) begin
            r_rcnt[i] <= '0;
            r_drop[i] <= 1'b1;
          end else begin
            r_rcnt[i] <= r_rcnt[i] + 8'd1;
            r_drop[i] <= 1'b0;
          end
        end else begin
          r_rcnt[i] <= '0;
          r_drop[i] <= 1'b0;
        end
      end
    end
  end

`ifdef ALLOC_STATS_EN
  logic [STAT_W-1:0] r_stat [N_PORTS];

  always_ff @(posedge clk) begin
    for (int p = 0; p < N_PORTS; p++) begin
      if (rst || clr_stats) begin
        r_stat[p] <= '0;
      end else if (w_ok[p] && (r_stat[p] != '1)) begin
        r_stat[p] <= r_stat[p] + 1'b1;
      end
    end
  end

  always_comb begin
    stat_grants = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      stat_grants[p*STAT_W +: STAT_W] = r_stat[p];
    end
  end
`endif

  always_comb begin
    gnt       = '0;
    out_sel   = '0;
    out_valid = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      out_sel[p*IN_W +: IN_W] = r_sel[p];
      out_valid[p] = (r_state[p] == ST_LOCKED) & in_valid[r_sel[p]];
      for (int i = 0; i < N_IN; i++) begin
        gnt[i*N_PORTS + p] = r_gnt_p[p][i];
      end
    end
  end

  assign drop_req = r_drop;
  assign abort    = r_abort;

endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench for switch_allocator: table of per-cycle vectors
// plus hand-written lock, abort, retry and reset sequences.
module tb_switch_allocator;
  import switch_allocator_pkg::*;

  localparam int NP = N_PORTS;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_valid, in_tail, in_retry;
  logic [23:0] in_req;
  logic [5:0]  link_up, out_ready;
  logic [23:0] gnt;
  logic [5:0]  out_valid, abort;
  logic [11:0] out_sel;
  logic [3:0]  drop_req;

  int n_chk = 0;
  int n_pass = 0;

  switch_allocator dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_req(in_req),
    .in_tail(in_tail), .in_retry(in_retry),
    .link_up(link_up), .out_ready(out_ready),
    .gnt(gnt), .out_valid(out_valid), .out_sel(out_sel),
    .drop_req(drop_req), .abort(abort)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  v;
    logic [23:0] rq;
    logic [5:0]  lk;
    logic [5:0]  rdy;
    logic [23:0] g;
    logic [5:0]  ov;
    logic [11:0] sel;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [23:0] rq(int i, int p);
    logic [23:0] r;
    r = '0;
    r[i*NP+p] = 1'b1;
    return r;
  endfunction

  function automatic vec_t mk(logic [3:0] v, logic [23:0] r,
                              logic [5:0] lk, logic [5:0] rdy,
                              logic [23:0] g, logic [5:0] ov,
                              logic [11:0] sel);
    vec_t t;
    t.v = v; t.rq = r; t.lk = lk; t.rdy = rdy;
    t.g = g; t.ov = ov; t.sel = sel;
    return t;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic chk_all(string nm, logic [23:0] g, logic [5:0] ov,
                         logic [11:0] sel, logic [3:0] dr,
                         logic [5:0] ab);
    chk({nm, ".gnt"}, 32'(gnt), 32'(g));
    chk({nm, ".out_valid"}, 32'(out_valid), 32'(ov));
    chk({nm, ".out_sel"}, 32'(out_sel), 32'(sel));
    chk({nm, ".drop_req"}, 32'(drop_req), 32'(dr));
    chk({nm, ".abort"}, 32'(abort), 32'(ab));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = '0; in_req = '0; in_tail = '0; in_retry = '0;
    link_up = '1; out_ready = '1;
  endtask

  initial begin
    logic [23:0] r3;
    idle();
    rst = 1'b1;
    step(); step();
    chk_all("reset", 24'h0, 6'h0, 12'h0, 4'h0, 6'h0);
    rst = 1'b0;

    r3 = rq(0, PORT_N) | rq(1, PORT_N) | rq(2, PORT_N);
    // single flit to E
    tbl.push_back(mk(4'h1, rq(0, PORT_E), 6'h3f, 6'h3f, 24'h2, 6'h02, 12'h0));
    tbl.push_back(mk(4'h1, rq(0, PORT_E), 6'h3f, 6'h3f, 24'h0, 6'h00, 12'h0));
    tbl.push_back(mk(4'h0, 24'h0, 6'h3f, 6'h3f, 24'h0, 6'h00, 12'h0));
    // RR rotation on N: 0,1,2,0
    tbl.push_back(mk(4'h7, r3, 6'h3f, 6'h3f, 24'h000001, 6'h01, 12'h000));
    tbl.push_back(mk(4'h7, r3, 6'h3f, 6'h3f, 24'h0, 6'h00, 12'h0));
    tbl.push_back(mk(4'h7, r3, 6'h3f, 6'h3f, 24'h000040, 6'h01, 12'h001));
    tbl.push_back(mk(4'h7, r3, 6'h3f, 6'h3f, 24'h0, 6'h00, 12'h0));
    tbl.push_back(mk(4'h7, r3, 6'h3f, 6'h3f, 24'h001000, 6'h01, 12'h002));
    tbl.push_back(mk(4'h7, r3, 6'h3f, 6'h3f, 24'h0, 6'h00, 12'h0));
    tbl.push_back(mk(4'h7, r3, 6'h3f, 6'h3f, 24'h000001, 6'h01, 12'h000));
    tbl.push_back(mk(4'h7, r3, 6'h3f, 6'h3f, 24'h0, 6'h00, 12'h0));
    tbl.push_back(mk(4'h0, 24'h0, 6'h3f, 6'h3f, 24'h0, 6'h00, 12'h0));
    // parallel grants E and N
    tbl.push_back(mk(4'h3, rq(0, PORT_E) | rq(1, PORT_N), 6'h3f, 6'h3f,
                     24'h000042, 6'h03, 12'h001));
    tbl.push_back(mk(4'h3, rq(0, PORT_E) | rq(1, PORT_N), 6'h3f, 6'h3f,
                     24'h0, 6'h00, 12'h0));
    tbl.push_back(mk(4'h0, 24'h0, 6'h3f, 6'h3f, 24'h0, 6'h00, 12'h0));
    // E link down: input 3 falls through to S
    tbl.push_back(mk(4'h8, rq(3, PORT_E) | rq(3, PORT_S), 6'h3d, 6'h3f,
                     24'h100000, 6'h04, 12'h030));
    tbl.push_back(mk(4'h8, rq(3, PORT_E) | rq(3, PORT_S), 6'h3d, 6'h3f,
                     24'h0, 6'h00, 12'h0));
    tbl.push_back(mk(4'h0, 24'h0, 6'h3f, 6'h3f, 24'h0, 6'h00, 12'h0));
    // W not ready, then ready
    tbl.push_back(mk(4'h4, rq(2, PORT_W), 6'h3f, 6'h37, 24'h0, 6'h00, 12'h0));
    tbl.push_back(mk(4'h4, rq(2, PORT_W), 6'h3f, 6'h3f,
                     24'h008000, 6'h08, 12'h080));
    tbl.push_back(mk(4'h4, rq(2, PORT_W), 6'h3f, 6'h3f, 24'h0, 6'h00, 12'h0));
    tbl.push_back(mk(4'h0, 24'h0, 6'h3f, 6'h3f, 24'h0, 6'h00, 12'h0));

    foreach (tbl[k]) begin
      in_valid  = tbl[k].v;
      in_tail   = tbl[k].v;
      in_req    = tbl[k].rq;
      link_up   = tbl[k].lk;
      out_ready = tbl[k].rdy;
      step();
      chk_all($sformatf("vec%0d", k), tbl[k].g, tbl[k].ov,
              tbl[k].sel, 4'h0, 6'h0);
    end
    idle();

    // 4-flit packet from input 1 on SER_E, input 3 waits
    in_valid = 4'hA;
    in_req   = rq(1, PORT_SER_E) | rq(3, PORT_SER_E);
    in_tail  = 4'h8;
    step();
    chk_all("ser.head", 24'h000800, 6'h20, 12'h400, 4'h0, 6'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk_all($sformatf("ser.body%0d", k), 24'h000800, 6'h20,
              12'h400, 4'h0, 6'h0);
    end
    in_tail = 4'hA;
    step();
    chk_all("ser.tail", 24'h0, 6'h00, 12'h0, 4'h0, 6'h0);
    in_valid = 4'h8;
    in_tail  = 4'h8;
    step();
    chk_all("ser.in3", 24'h800000, 6'h20, 12'hC00, 4'h0, 6'h0);
    step();
    chk_all("ser.in3rel", 24'h0, 6'h00, 12'h0, 4'h0, 6'h0);
    idle();
    step();

    // link drop on W mid-packet
    in_valid = 4'h1;
    in_req   = rq(0, PORT_W);
    step();
    chk_all("abt.lock", 24'h000008, 6'h08, 12'h0, 4'h0, 6'h0);
    step();
    chk_all("abt.hold", 24'h000008, 6'h08, 12'h0, 4'h0, 6'h0);
    link_up = 6'h37;
    step();
    chk_all("abt.pulse", 24'h0, 6'h00, 12'h0, 4'h0, 6'h08);
    step();
    chk_all("abt.once", 24'h0, 6'h00, 12'h0, 4'h0, 6'h00);
    idle();
    step();

    // retry counter on input 2
    in_valid = 4'h4;
    in_retry = 4'h4;
    for (int k = 1; k <= 16; k++) begin
      step();
      chk($sformatf("retry%0d", k), 32'(drop_req),
          (k == 8 || k == 16) ? 32'h4 : 32'h0);
    end
    in_retry = 4'h0;
    step();
    chk("retry.off", 32'(drop_req), 32'h0);
    in_retry = 4'h4;
    for (int k = 0; k < 5; k++) step();
    in_valid = 4'h0;
    step();
    in_valid = 4'h4;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk($sformatf("retry.rs%0d", k), 32'(drop_req),
          (k == 8) ? 32'h4 : 32'h0);
    end
    idle();
    step();

    // reset while locked
    in_valid = 4'h1;
    in_req   = rq(0, PORT_N);
    step();
    chk_all("rst.lock", 24'h000001, 6'h01, 12'h0, 4'h0, 6'h0);
    rst = 1'b1;
    step();
    chk_all("rst.clear", 24'h0, 6'h00, 12'h0, 4'h0, 6'h0);
    rst = 1'b0;
    idle();
    step();
    chk_all("rst.after", 24'h0, 6'h00, 12'h0, 4'h0, 6'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
